ram_dp_init: RTL and testbench
==============================

RAM_DP_INIT -- requirements
Module: ram_dp_init

Interface
REQ-001 The block SHALL take parameter DATA_W, default 3, as the data word width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, as the address width; depth SHALL be DEPTH = 2**ADDR_W.
REQ-003 The block SHALL take parameter INIT_VAL, default 0 (DATA_W bits), as the value written to every word by the clear sequence.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered.
REQ-005 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-007 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-010 The block SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-011 The block SHALL have port rd_data, output, DATA_W bits: read result.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: rd_data holds a new result this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: clear sequence in progress, requests ignored.
REQ-014 The block SHALL have port dropped, output, 1 bit: one-cycle pulse, a request was discarded because busy.

Function
REQ-015 All six request inputs SHALL be registered once on entry (input stage) before use.
REQ-016 A write sampled at edge N SHALL commit to the array at edge N+1.
REQ-017 A read sampled at edge N SHALL present rd_data with rd_valid=1 during the cycle after edge N+2 (latency 2).
REQ-018 rd_valid SHALL be high for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back valid results.
REQ-019 When rd_valid=0, rd_data SHALL hold its last value.
REQ-020 When registered read and write in the same stage target the same address, rd_data SHALL return the new write data (write-first bypass).
REQ-021 A read sampled one or more cycles after a write to the same address SHALL return the written data without bypass.
REQ-022 FSM states SHALL be CLEAR and READY.
REQ-023 After reset release, the FSM SHALL enter CLEAR and write INIT_VAL to addresses 0 through DEPTH-1, one per cycle, ascending.
REQ-024 The FSM SHALL move CLEAR -> READY on the cycle after address DEPTH-1 is written; busy SHALL be 1 exactly while in CLEAR.
REQ-025 The clear counter SHALL be ADDR_W bits and SHALL NOT wrap back into a second pass.
REQ-026 Registered wr_en or rd_en seen while busy=1 SHALL be discarded (no array write, no rd_valid).
REQ-027 Each discarded request SHALL raise dropped for one cycle (wr_en and rd_en together give one pulse).
REQ-028 READY SHALL be terminal until the next reset.

Reset
REQ-029 Asserting Reset_n=0 SHALL immediately force: input-stage enables 0, rd_valid 0, rd_data 0, dropped 0, busy 1, FSM CLEAR, clear counter 0.
REQ-030 Reset SHALL NOT directly clear array contents; the contents are defined only by the clear sequence.
REQ-031 Reset asserted mid-clear SHALL restart the clear from address 0 after release, for a full DEPTH cycles.

Structure
REQ-032 The FSM state typedef (ram_state_t: CLEAR, READY) SHALL reside in shared package ram_pkg.
REQ-033 The storage array SHALL be a sub-module ram_sdp: simple dual-port, synchronous read, one write port, one read port, no reset.
REQ-034 Input registering, clear FSM/counter, write-port mux (clear vs user), bypass compare, and output pipeline SHALL live in ram_dp_init.

Verification (DATA_W=3, ADDR_W=5)
REQ-035 Reset low 3 cycles, then high -> busy=1 for exactly 32 cycles then 0; reads of addresses 0..31 -> rd_data 3'b000.
REQ-036 Write addr 1 data 3'b001, next cycle read addr 1 -> rd_data 3'b001, with rd_valid high 2 cycles after the read is sampled.
REQ-037 Same-cycle write addr 2 data 3'b010 with read addr 2 -> rd_data 3'b010 (bypass); then read addr 2 with write disabled -> 3'b010.
REQ-038 Write addr 31 data 3'b111, then read 31, 0 back-to-back -> 3'b111, 3'b000 on consecutive cycles, rd_valid high both.
REQ-039 wr_en=1 addr 5 data 3'b101 and rd_en=1 during busy -> dropped pulses, no rd_valid; after clear, read addr 5 -> 3'b000.
REQ-040 Reset asserted when clear counter=10 -> outputs return to reset values; after release, busy high 32 full cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the initialised dual-port RAM: clear-sequence FSM states.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port storage array: one write port, one registered read port, no reset.
module ram_sdp #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Array write and synchronous read (read-first on address collision)
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ram_dp_init.sv
// Dual-port RAM that fills itself with INIT_VAL after reset, with registered
// requests, write-first bypass on same-stage collisions and a 2-cycle read pipe.
module ram_dp_init
  import ram_pkg::*;
#(
  parameter int              DATA_W   = 3,
  parameter int              ADDR_W   = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              dropped
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_r;

  ram_state_t        state_r;
  ram_state_t        state_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [ADDR_W-1:0] clr_cnt_nxt_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              drop_s;
  logic [DATA_W-1:0] sdp_rdata_s;

  logic              rd_pend_r;
  logic              byp_r;
  logic [DATA_W-1:0] byp_data_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              dropped_r;

  // Input stage: every request input is registered once before use
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= ZERO_ADDR;
      wr_data_r <= ZERO_DATA;
      rd_en_r   <= 1'b0;
      rd_addr_r <= ZERO_ADDR;
    end else begin
      wr_en_r   <= wr_en;
      wr_addr_r <= wr_addr;
      wr_data_r <= wr_data;
      rd_en_r   <= rd_en;
      rd_addr_r <= rd_addr;
    end
  end

  // Clear FSM state and sweep counter
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= CLEAR;
      clr_cnt_r <= ZERO_ADDR;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next state, write-port mux and request acceptance
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    mem_we_s      = 1'b0;
    mem_waddr_s   = wr_addr_r;
    mem_wdata_s   = wr_data_r;
    wr_acc_s      = 1'b0;
    rd_acc_s      = 1'b0;
    drop_s        = 1'b0;
    case (state_r)
      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_cnt_r;
        mem_wdata_s = INIT_VAL;
        drop_s      = wr_en_r | rd_en_r;
        // Counter parks on the last address so the sweep never wraps
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s = READY;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + ONE_ADDR;
        end
      end
      READY: begin
        mem_we_s = wr_en_r;
        wr_acc_s = wr_en_r;
        rd_acc_s = rd_en_r;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_cnt_nxt_s = ZERO_ADDR;
      end
    endcase
  end

  ram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sdp (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .re    (rd_acc_s),
    .raddr (rd_addr_r),
    .rdata (sdp_rdata_s)
  );

  // Array-access stage: track pending read and capture collision bypass data
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_pend_r  <= 1'b0;
      byp_r      <= 1'b0;
      byp_data_r <= ZERO_DATA;
      dropped_r  <= 1'b0;
    end else begin
      rd_pend_r  <= rd_acc_s;
      byp_r      <= rd_acc_s & wr_acc_s & (rd_addr_r == wr_addr_r);
      byp_data_r <= wr_data_r;
      dropped_r  <= drop_s;
    end
  end

  // Output stage: rd_data only updates with a valid result, else holds
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= ZERO_DATA;
    end else begin
      rd_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rd_data_r <= byp_r ? byp_data_r : sdp_rdata_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign dropped  = dropped_r;
  assign busy     = (state_r == CLEAR);

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: directed table, clear/reset sequences and random
// traffic checked against an array-based reference model.
module tb_ram_dp_init;

  logic       clk;
  logic       Reset_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [2:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [2:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       dropped;

  ram_dp_init #(
    .DATA_W   (3),
    .ADDR_W   (5),
    .INIT_VAL (3'b000)
  ) dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .dropped  (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int fails;

  // Reference model: edges since reset release, array contents, result pipe
  int         n_edges;
  logic [2:0] mem_m [32];
  logic       vq1, vq2;
  logic [2:0] dq1, dq2;
  logic       drop_q;
  logic [2:0] last_d;
  int         busy_cnt;

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [2:0] wd;
    logic       re;
    logic [4:0] ra;
    logic       ev;
    logic [2:0] ed;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    vq1 = 1'b0;
    vq2 = 1'b0;
    dq1 = 3'd0;
    dq2 = 3'd0;
    drop_q = 1'b0;
    last_d = 3'd0;
    for (int i = 0; i < 32; i++) mem_m[i] = 3'b000;
  endtask

  // Apply one request, advance one edge, update model, compare all outputs
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [2:0] wd,
                       input logic re, input logic [4:0] ra);
    logic       acc;
    logic       ev;
    logic [2:0] ed;
    logic       edrop;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    @(posedge clk);
    #1;
    n_edges++;
    acc = (n_edges >= 32);
    ev  = vq2;
    ed  = dq2;
    vq2 = vq1;
    dq2 = dq1;
    if (acc && we) mem_m[wa] = wd;
    vq1 = acc && re;
    dq1 = mem_m[ra];
    edrop  = drop_q;
    drop_q = !acc && (we || re);
    if (ev) last_d = ed;
    if (busy) busy_cnt++;
    chk("busy", 32'(busy), 32'(n_edges < 32));
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("rd_data", 32'(rd_data), 32'(last_d));
    chk("dropped", 32'(dropped), 32'(edrop));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 5'd0, 3'd0, 1'b0, 5'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped), 32'd0);
  endtask

  // Assert reset asynchronously, hold for some edges, release after an edge
  task automatic do_reset(input int hold);
    wr_en = 1'b0;
    rd_en = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_now");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
    end
    Reset_n = 1'b1;
    model_reset();
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 32; a++) cycle(1'b0, 5'd0, 3'd0, 1'b1, 5'(a));
    idle(2);
  endtask

  initial begin
    vectors  = 0;
    fails    = 0;
    busy_cnt = 0;
    Reset_n  = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 3'd0;
    rd_en    = 1'b0;
    rd_addr  = 5'd0;
    model_reset();

    tbl[0] = '{1'b1, 5'd1,  3'd1, 1'b0, 5'd0,  1'b0, 3'd0};
    tbl[1] = '{1'b0, 5'd0,  3'd0, 1'b1, 5'd1,  1'b0, 3'd0};
    tbl[2] = '{1'b1, 5'd2,  3'd2, 1'b1, 5'd2,  1'b0, 3'd0};
    tbl[3] = '{1'b0, 5'd0,  3'd0, 1'b1, 5'd2,  1'b1, 3'd1};
    tbl[4] = '{1'b1, 5'd31, 3'd7, 1'b0, 5'd0,  1'b1, 3'd2};
    tbl[5] = '{1'b0, 5'd0,  3'd0, 1'b1, 5'd31, 1'b1, 3'd2};
    tbl[6] = '{1'b0, 5'd0,  3'd0, 1'b1, 5'd0,  1'b0, 3'd2};
    tbl[7] = '{1'b0, 5'd0,  3'd0, 1'b0, 5'd0,  1'b1, 3'd7};
    tbl[8] = '{1'b0, 5'd0,  3'd0, 1'b0, 5'd0,  1'b1, 3'd0};
    tbl[9] = '{1'b0, 5'd0,  3'd0, 1'b0, 5'd0,  1'b0, 3'd0};

    #2;
    do_reset(3);

    // Requests during the clear are dropped; busy lasts exactly 32 cycles
    cycle(1'b1, 5'd5, 3'd5, 1'b1, 5'd0);
    idle(34);
    chk("busy_len", 32'(busy_cnt), 32'd32);

    // Whole array reads back INIT_VAL, including the dropped write to 5
    read_sweep();

    // Directed write/read/bypass/back-to-back table
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      chk("tbl_valid", 32'(rd_valid), 32'(tbl[i].ev));
      chk("tbl_data", 32'(rd_data), 32'(tbl[i].ed));
    end

    // Random traffic with a narrow address range to force collisions
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(28, 31)), 3'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(28, 31)));
    end
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom));
    end
    idle(2);

    // Reset mid-clear at counter 10, then a full restart with random requests
    do_reset(2);
    idle(10);
    do_reset(3);
    for (int i = 0; i < 36; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom));
    end
    chk("busy_len_restart", 32'(busy_cnt), 32'd32);
    idle(2);
    read_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
